// File: rtl/button_mmio_ctrl_if.sv
// dmem-side bus bundle for button_mmio_ctrl: processor address/store/read paths plus dmem read data.
// The master side is the surrounding system; the slave side is the controller.
interface button_mmio_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] address_dmem;
  logic [31:0]       data;
  logic              wren;
  logic [31:0]       q_mem;
  logic [31:0]       q_proc;
  logic              wren_mem;

  modport master (
    output address_dmem, data, wren, q_mem,
    input  q_proc, wren_mem
  );

  modport slave (
    input  address_dmem, data, wren, q_mem,
    output q_proc, wren_mem
  );
endinterface

// File: rtl/button_mmio_ctrl.sv
// Push-button front end: per-channel synchroniser, debouncer and rising-edge detector,
// exposed as LEVEL/EVENT/MASK/COUNT words spliced into the dmem read/write path.
module button_mmio_ctrl #(
  parameter int              NUM_BTN         = 4,
  parameter int              DEBOUNCE_CYCLES = 50000,
  parameter int              ADDR_W          = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = 12'hFF0,
  parameter int              CNT_W           = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  button_mmio_ctrl_if.slave  bus,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               irq
);

  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_BTN-1:0] sync1_r;
  logic [NUM_BTN-1:0] sync2_r;
  logic [DB_W-1:0]    db_cnt_r [NUM_BTN];
  logic [NUM_BTN-1:0] level_r;
  logic [NUM_BTN-1:0] level_prev_r;
  logic [NUM_BTN-1:0] event_r;
  logic [NUM_BTN-1:0] mask_r;
  logic [CNT_W-1:0]   count_r;
  logic               irq_r;

  logic               hit_s;
  logic [1:0]         offset_s;
  logic               reg_wr_s;
  logic [NUM_BTN-1:0] rise_s;
  logic [NUM_BTN-1:0] event_next_s;
  logic [NUM_BTN-1:0] mask_next_s;
  logic [CNT_W-1:0]   count_base_s;
  logic [CNT_W-1:0]   count_next_s;
  logic [31:0]        rdata_s;

  function automatic logic [5:0] popcount(input logic [NUM_BTN-1:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < NUM_BTN; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [5:0] b);
    logic [CNT_W+5:0] sum;
    sum = {6'd0, a} + {{CNT_W{1'b0}}, b};
    if (sum > {6'd0, CNT_MAX}) begin
      return CNT_MAX;
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

  assign hit_s    = (bus.address_dmem[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
  assign offset_s = bus.address_dmem[1:0];
  assign reg_wr_s = bus.wren & hit_s;
  assign rise_s   = level_r & ~level_prev_r;

  // Synchronise, then require DEBOUNCE_CYCLES consecutive disagreeing samples before flipping the level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r      <= '0;
      sync2_r      <= '0;
      level_r      <= '0;
      level_prev_r <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r      <= btn_raw;
      sync2_r      <= sync1_r;
      level_prev_r <= level_r;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2_r[i] == level_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          level_r[i]  <= ~level_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
        end
      end
    end
  end

  // Register writes; a same-cycle edge wins over W1C and is added on top of a COUNT clear.
  always_comb begin
    event_next_s = event_r | rise_s;
    mask_next_s  = mask_r;
    count_base_s = count_r;
    if (reg_wr_s) begin
      case (offset_s)
        2'd1:    event_next_s = (event_r & ~bus.data[NUM_BTN-1:0]) | rise_s;
        2'd2:    mask_next_s  = bus.data[NUM_BTN-1:0];
        2'd3:    count_base_s = '0;
        default: mask_next_s  = mask_r;
      endcase
    end else begin
      mask_next_s = mask_r;
    end
    count_next_s = sat_add(count_base_s, popcount(rise_s));
  end

  // Architectural register state and the registered interrupt.
  always_ff @(posedge clock) begin
    if (reset) begin
      event_r <= '0;
      mask_r  <= '0;
      count_r <= '0;
      irq_r   <= 1'b0;
    end else begin
      event_r <= event_next_s;
      mask_r  <= mask_next_s;
      count_r <= count_next_s;
      irq_r   <= |(event_r & mask_r);
    end
  end

  // Zero-latency read mux; unused upper bits read as zero.
  always_comb begin
    rdata_s = 32'd0;
    case (offset_s)
      2'd0:    rdata_s[NUM_BTN-1:0] = level_r;
      2'd1:    rdata_s[NUM_BTN-1:0] = event_r;
      2'd2:    rdata_s[NUM_BTN-1:0] = mask_r;
      2'd3:    rdata_s[CNT_W-1:0]   = count_r;
      default: rdata_s              = 32'd0;
    endcase
  end

  assign bus.q_proc   = hit_s ? rdata_s : bus.q_mem;
  assign bus.wren_mem = bus.wren & ~hit_s;
  assign btn_level    = level_r;
  assign irq          = irq_r;

endmodule

// File: tb/tb_button_mmio_ctrl.sv
// Self-checking bench for button_mmio_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the register map and debouncer.
module tb_button_mmio_ctrl;

  localparam int DB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] raw1, raw2;
  logic [3:0] lvl1, lvl2;
  logic       irq1, irq2;

  int tests = 0;
  int fails = 0;

  button_mmio_ctrl_if #(.ADDR_W(12)) bus1 (), bus2 ();

  always #5 clock = ~clock;

  button_mmio_ctrl #(
    .NUM_BTN(4), .DEBOUNCE_CYCLES(DB), .ADDR_W(12), .BASE_ADDR(12'hFF0), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset), .btn_raw(raw1), .bus(bus1), .btn_level(lvl1), .irq(irq1)
  );

  button_mmio_ctrl #(
    .NUM_BTN(4), .DEBOUNCE_CYCLES(1), .ADDR_W(12), .BASE_ADDR(12'hFF0), .CNT_W(16)
  ) dut_fast (
    .clock(clock), .reset(reset), .btn_raw(raw2), .bus(bus2), .btn_level(lvl2), .irq(irq2)
  );

  // Behavioural model of dut: samples seen, consecutive disagreeing-sample runs, registers.
  logic [3:0] m_seen1, m_seen2;
  int         m_run [4];
  logic [3:0] m_level, m_prev, m_event, m_mask;
  int         m_count;
  logic       m_irq;

  task automatic model_step();
    logic [3:0] rises;
    logic       hit;
    logic       wr;
    if (reset) begin
      m_seen1 = 4'd0; m_seen2 = 4'd0; m_level = 4'd0; m_prev = 4'd0;
      m_event = 4'd0; m_mask = 4'd0; m_count = 0; m_irq = 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      rises = m_level & ~m_prev;
      hit   = (bus1.address_dmem[11:2] == 10'h3FC);
      wr    = bus1.wren && hit;
      m_irq = |(m_event & m_mask);
      if (wr && bus1.address_dmem[1:0] == 2'd1) m_event = m_event & ~bus1.data[3:0];
      m_event = m_event | rises;
      if (wr && bus1.address_dmem[1:0] == 2'd2) m_mask = bus1.data[3:0];
      if (wr && bus1.address_dmem[1:0] == 2'd3) m_count = 0;
      m_count = m_count + $countones(rises);
      if (m_count > 65535) m_count = 65535;
      m_prev = m_level;
      for (int i = 0; i < 4; i++) begin
        if (m_seen2[i] != m_level[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB) begin
            m_level[i] = ~m_level[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_seen2 = m_seen1;
      m_seen1 = raw1;
    end
  endtask

  function automatic logic [31:0] m_qproc(input logic [11:0] addr, input logic [31:0] qmem);
    if (addr[11:2] != 10'h3FC) return qmem;
    case (addr[1:0])
      2'd0:    return {28'd0, m_level};
      2'd1:    return {28'd0, m_event};
      2'd2:    return {28'd0, m_mask};
      default: return 32'(m_count);
    endcase
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    bus1.address_dmem = 12'h000; bus1.data = 32'd0; bus1.wren = 1'b0; bus1.q_mem = 32'd0;
    bus2.address_dmem = 12'hFF3; bus2.data = 32'd0; bus2.wren = 1'b0; bus2.q_mem = 32'd0;
  endtask

  task automatic do_reset();
    raw1 = 4'd0; raw2 = 4'd0;
    idle_bus();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (lvl1 !== 4'd0) begin fails++; $display("FAIL rst_level: got %h expected 0", lvl1); end
    tests++; if (irq1 !== 1'b0) begin fails++; $display("FAIL rst_irq: got %b expected 0", irq1); end
    for (int k = 0; k < 4; k++) begin
      bus1.address_dmem = 12'hFF0 + 12'(k); #1;
      tests++;
      if (bus1.q_proc !== 32'd0) begin fails++; $display("FAIL rst_reg%0d: got %h expected 0", k, bus1.q_proc); end
    end
    bus1.address_dmem = 12'h100; bus1.q_mem = 32'hA5A5_1234; #1;
    tests++;
    if (bus1.q_proc !== 32'hA5A5_1234) begin fails++; $display("FAIL rst_passthru: got %h expected a5a51234", bus1.q_proc); end
    idle_bus();
  endtask

  task automatic test_debounce();
    do_reset();
    raw1 = 4'b0001;
    repeat (5) tick();
    tests++; if (lvl1[0] !== 1'b0) begin fails++; $display("FAIL deb_early: got %b expected 0", lvl1[0]); end
    tick();
    tests++; if (lvl1 !== 4'b0001) begin fails++; $display("FAIL deb_level: got %h expected 1", lvl1); end
    tick();
    bus1.address_dmem = 12'hFF1; #1;
    tests++; if (bus1.q_proc !== 32'd1) begin fails++; $display("FAIL deb_event: got %h expected 1", bus1.q_proc); end
    bus1.address_dmem = 12'hFF3; #1;
    tests++; if (bus1.q_proc !== 32'd1) begin fails++; $display("FAIL deb_count: got %h expected 1", bus1.q_proc); end
    raw1 = 4'b0000;
    repeat (8) tick();
    tests++; if (lvl1 !== 4'd0) begin fails++; $display("FAIL deb_release: got %h expected 0", lvl1); end
    tests++; if (bus1.q_proc !== 32'd1) begin fails++; $display("FAIL deb_fall_count: got %h expected 1", bus1.q_proc); end
  endtask

  task automatic test_glitch();
    do_reset();
    raw1 = 4'b0010;
    repeat (3) tick();
    raw1 = 4'b0000;
    repeat (10) tick();
    tests++; if (lvl1 !== 4'd0) begin fails++; $display("FAIL glitch_level: got %h expected 0", lvl1); end
    bus1.address_dmem = 12'hFF1; #1;
    tests++; if (bus1.q_proc !== 32'd0) begin fails++; $display("FAIL glitch_event: got %h expected 0", bus1.q_proc); end
    bus1.address_dmem = 12'hFF3; #1;
    tests++; if (bus1.q_proc !== 32'd0) begin fails++; $display("FAIL glitch_count: got %h expected 0", bus1.q_proc); end
  endtask

  task automatic test_irq();
    do_reset();
    bus1.address_dmem = 12'hFF2; bus1.data = 32'h5; bus1.wren = 1'b1;
    tick();
    bus1.wren = 1'b0;
    raw1 = 4'b0100;
    repeat (7) tick();
    tests++; if (irq1 !== 1'b0) begin fails++; $display("FAIL irq_early: got %b expected 0", irq1); end
    tick();
    tests++; if (irq1 !== 1'b1) begin fails++; $display("FAIL irq_set: got %b expected 1", irq1); end
    bus1.address_dmem = 12'hFF1; bus1.data = 32'h4; bus1.wren = 1'b1;
    tick();
    bus1.wren = 1'b0;
    tests++; if (irq1 !== 1'b1) begin fails++; $display("FAIL irq_hold: got %b expected 1", irq1); end
    tick();
    tests++; if (irq1 !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b expected 0", irq1); end
    raw1 = 4'b0110;
    repeat (10) tick();
    tests++; if (irq1 !== 1'b0) begin fails++; $display("FAIL irq_masked: got %b expected 0", irq1); end
  endtask

  task automatic test_mmio();
    logic [31:0] r;
    do_reset();
    bus1.address_dmem = 12'hFF2; bus1.data = 32'hDEAD; bus1.wren = 1'b1; #1;
    tests++; if (bus1.wren_mem !== 1'b0) begin fails++; $display("FAIL mmio_block: got %b expected 0", bus1.wren_mem); end
    tick();
    bus1.wren = 1'b0; #1;
    tests++; if (bus1.q_proc !== 32'hD) begin fails++; $display("FAIL mmio_mask: got %h expected d", bus1.q_proc); end
    r = $urandom;
    bus1.address_dmem = 12'h010; bus1.wren = 1'b1; bus1.q_mem = r; #1;
    tests++; if (bus1.wren_mem !== 1'b1) begin fails++; $display("FAIL mmio_fwd: got %b expected 1", bus1.wren_mem); end
    tests++; if (bus1.q_proc !== r) begin fails++; $display("FAIL mmio_qmem: got %h expected %h", bus1.q_proc, r); end
    tick();
    bus1.address_dmem = 12'hFF0; bus1.data = 32'hFFFF_FFFF;
    tick();
    bus1.wren = 1'b0; #1;
    tests++; if (bus1.q_proc !== 32'd0) begin fails++; $display("FAIL mmio_level_ro: got %h expected 0", bus1.q_proc); end
    bus1.address_dmem = 12'hFF2; #1;
    tests++; if (bus1.q_proc !== 32'hD) begin fails++; $display("FAIL mmio_mask_kept: got %h expected d", bus1.q_proc); end
  endtask

  task automatic test_collision();
    do_reset();
    raw1 = 4'b1000;
    repeat (6) tick();
    tests++; if (lvl1[3] !== 1'b1) begin fails++; $display("FAIL col_level: got %b expected 1", lvl1[3]); end
    bus1.address_dmem = 12'hFF1; bus1.data = 32'h8; bus1.wren = 1'b1;
    tick();
    bus1.wren = 1'b0; #1;
    tests++; if (bus1.q_proc !== 32'h8) begin fails++; $display("FAIL col_set_wins: got %h expected 8", bus1.q_proc); end
    bus1.wren = 1'b1;
    tick();
    bus1.wren = 1'b0; #1;
    tests++; if (bus1.q_proc !== 32'h0) begin fails++; $display("FAIL col_w1c: got %h expected 0", bus1.q_proc); end
    raw1 = 4'b0000;
    repeat (8) tick();
    raw1 = 4'b1001;
    repeat (6) tick();
    bus1.address_dmem = 12'hFF3; bus1.data = 32'h0; bus1.wren = 1'b1;
    tick();
    bus1.wren = 1'b0; #1;
    tests++; if (bus1.q_proc !== 32'd2) begin fails++; $display("FAIL col_count: got %h expected 2", bus1.q_proc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    raw1 = 4'b0001;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    tests++; if (lvl1 !== 4'd0 || irq1 !== 1'b0) begin fails++; $display("FAIL mid_outputs: got %h/%b expected 0/0", lvl1, irq1); end
    for (int k = 0; k < 4; k++) begin
      bus1.address_dmem = 12'hFF0 + 12'(k); #1;
      tests++;
      if (bus1.q_proc !== 32'd0) begin fails++; $display("FAIL mid_reg%0d: got %h expected 0", k, bus1.q_proc); end
    end
    reset = 1'b0;
    repeat (5) tick();
    tests++; if (lvl1 !== 4'd0) begin fails++; $display("FAIL mid_fresh_early: got %h expected 0", lvl1); end
    tick();
    tests++; if (lvl1 !== 4'b0001) begin fails++; $display("FAIL mid_fresh_level: got %h expected 1", lvl1); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      raw2 = ~raw2;
      tick();
    end
    repeat (4) tick();
    tests++; if (bus2.q_proc !== 32'd2000) begin fails++; $display("FAIL sat_partial: got %0d expected 2000", bus2.q_proc); end
    tests++; if (lvl2 !== 4'd0) begin fails++; $display("FAIL sat_level: got %h expected 0", lvl2); end
    for (int k = 0; k < 32000; k++) begin
      raw2 = ~raw2;
      tick();
    end
    repeat (4) tick();
    tests++; if (bus2.q_proc !== 32'h0000_FFFF) begin fails++; $display("FAIL sat_full: got %h expected ffff", bus2.q_proc); end
    bus2.wren = 1'b1;
    tick();
    bus2.wren = 1'b0; #1;
    tests++; if (bus2.q_proc !== 32'd0) begin fails++; $display("FAIL sat_clear: got %h expected 0", bus2.q_proc); end
  endtask

  task automatic test_random();
    logic [31:0] exp_q;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) raw1[b] = ~raw1[b];
      end
      if ($urandom_range(0, 9) < 7) bus1.address_dmem = 12'hFF0 + 12'($urandom_range(0, 3));
      else bus1.address_dmem = 12'($urandom);
      bus1.wren  = ($urandom_range(0, 3) == 0);
      bus1.data  = $urandom;
      bus1.q_mem = $urandom;
      reset      = ($urandom_range(0, 299) == 0);
      #1;
      exp_q = m_qproc(bus1.address_dmem, bus1.q_mem);
      tests++;
      if (bus1.q_proc !== exp_q) begin fails++; $display("FAIL rnd_qproc c=%0d: got %h expected %h", c, bus1.q_proc, exp_q); end
      tests++;
      if (bus1.wren_mem !== (bus1.wren && bus1.address_dmem[11:2] != 10'h3FC)) begin
        fails++; $display("FAIL rnd_wren_mem c=%0d: got %b", c, bus1.wren_mem);
      end
      tests++;
      if (lvl1 !== m_level) begin fails++; $display("FAIL rnd_level c=%0d: got %h expected %h", c, lvl1, m_level); end
      tests++;
      if (irq1 !== m_irq) begin fails++; $display("FAIL rnd_irq c=%0d: got %b expected %b", c, irq1, m_irq); end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    raw1 = 4'd0; raw2 = 4'd0;
    idle_bus();
    test_reset();
    test_debounce();
    test_glitch();
    test_irq();
    test_mmio();
    test_collision();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
